conv11_input: RTL and testbench

Input-side stream reader for the conv11 layer. On `start`, it reads `length` consecutive words from the feature-map memory through a synchronous read port with 1-cycle latency. Each word is delivered to the conv11 compute core over a valid/ready stream, buffered by a small credit-controlled FIFO. A one-cycle `done` pulse marks the end of each transfer.

---
 rtl/conv11_input.sv | 180 ++++++++++++++++++
 tb/tb_conv11_input.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv11_input.sv
// conv11_input
//   Input-side stream reader for the conv11 layer. On an accepted start it
//   reads `length` consecutive words starting at `base_addr` from a
//   1-cycle-latency synchronous memory port and forwards them, in address
//   order, over a valid/ready stream. A small FIFO buffers the stream and a
//   credit check on read issue keeps it from overflowing.
//
//   Optional feature: define CONV11_INPUT_STALL_CNT_EN to add a 16-bit
//   saturating `stall_cnt` output counting valid-but-not-ready cycles of the
//   current transfer.
//
// Ports
//   clk, rst      : clock, synchronous active-high reset
//   start         : begin a transfer (only honoured while idle)
//   base_addr     : first word address, latched on accepted start
//   length        : word count, latched on accepted start
//   busy          : high whenever not idle
//   done          : one-cycle pulse after the last word is transferred
//   mem_rd_en     : memory read strobe
//   mem_addr      : memory read address
//   mem_rd_data   : memory read data, valid the cycle after mem_rd_en
//   valid_out     : stream valid (FIFO not empty)
//   ready_in      : downstream ready
//   data_out      : stream data (FIFO head)
//   stall_cnt     : (CONV11_INPUT_STALL_CNT_EN only) stall cycle count
module conv11_input #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 10,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] base_addr,
   input  logic [ADDR_WIDTH:0]   length,
   output logic                  busy,
   output logic                  done,
   output logic                  mem_rd_en,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   input  logic [DATA_WIDTH-1:0] mem_rd_data,
   output logic                  valid_out,
   input  logic                  ready_in,
   output logic [DATA_WIDTH-1:0] data_out
`ifdef CONV11_INPUT_STALL_CNT_EN
   ,
   output logic [15:0]           stall_cnt
`endif
);

   localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CntW = PtrW + 1;
   localparam int unsigned LenW = ADDR_WIDTH + 1;

   typedef enum logic [1:0] {StIdle, StFetch, StDrain, StDone} state_e;

   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] base_q;
   logic [LenW-1:0]       length_q;
   logic [LenW-1:0]       issued_q;
   logic [LenW-1:0]       sent_q;
   logic [LenW-1:0]       sent_inc;
   logic                  inflight_q;

   logic [DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
   logic [PtrW-1:0]       wr_ptr_q, rd_ptr_q;
   logic [CntW-1:0]       count_q;

   logic accept;
   logic issue;
   logic xfer;
   logic credit_ok;
   logic fifo_empty;

   assign accept     = (state_q == StIdle) && start;
   assign fifo_empty = (count_q == '0);
   assign valid_out  = !fifo_empty;
   assign data_out   = fifo_empty ? '0 : fifo_mem[rd_ptr_q];
   assign xfer       = valid_out && ready_in;
   assign sent_inc   = sent_q + LenW'(xfer);

   // A read in flight already owns a FIFO slot, so it counts as a credit.
   assign credit_ok  = (CntW'(inflight_q) + count_q) < CntW'(FIFO_DEPTH);
   assign issue      = (state_q == StFetch) && (issued_q < length_q) && credit_ok;

   assign mem_rd_en  = issue;
   assign mem_addr   = issue ? (base_q + issued_q[ADDR_WIDTH-1:0]) : '0;

   assign busy       = (state_q != StIdle);
   assign done       = (state_q == StDone);

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d = (length == '0) ? StDone : StFetch;
            end
         end
         StFetch: begin
            if (issued_q == length_q) begin
               state_d = StDrain;
            end
         end
         StDrain: begin
            // Look ahead at this cycle's transfer so done lands in the
            // cycle right after the last word leaves.
            if (sent_inc == length_q) begin
               state_d = StDone;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         base_q     <= '0;
         length_q   <= '0;
         issued_q   <= '0;
         sent_q     <= '0;
         inflight_q <= 1'b0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
      end else begin
         state_q    <= state_d;
         inflight_q <= issue;
         if (accept) begin
            base_q   <= base_addr;
            length_q <= length;
            issued_q <= '0;
            sent_q   <= '0;
         end else begin
            if (issue) begin
               issued_q <= issued_q + 1'b1;
            end
            if (xfer) begin
               sent_q <= sent_inc;
            end
         end
         // The FIFO write slot is the cycle after each read strobe.
         if (inflight_q) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
         end
         if (xfer) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         count_q <= count_q + CntW'(inflight_q) - CntW'(xfer);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && inflight_q) begin
         fifo_mem[wr_ptr_q] <= mem_rd_data;
      end
   end

`ifdef CONV11_INPUT_STALL_CNT_EN
   logic [15:0] stall_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_q <= '0;
      end else if (accept) begin
         stall_q <= '0;
      end else if (valid_out && !ready_in && (stall_q != 16'hFFFF)) begin
         stall_q <= stall_q + 16'd1;
      end
   end

   assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_conv11_input.sv
// tb_conv11_input
//   Self-checking bench for conv11_input. A memory model with random contents
//   answers reads one cycle later. A reference model kept in terms of words
//   issued/sent per transfer checks every cycle on the falling edge: busy,
//   done timing, read addresses, data order, handshake stability, FIFO
//   occupancy bound, reset values and (with CONV11_INPUT_STALL_CNT_EN)
//   stall_cnt. Directed cases pin the model with literal cycle numbers.
module tb_conv11_input;

   localparam int DW = 32;
   localparam int AW = 10;
   localparam int FD = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [AW-1:0] base_addr;
   logic [AW:0]   length;
   logic          busy;
   logic          done;
   logic          mem_rd_en;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_rd_data;
   logic          valid_out;
   logic          ready_in;
   logic [DW-1:0] data_out;
`ifdef CONV11_INPUT_STALL_CNT_EN
   logic [15:0]   stall_cnt;
`endif

   conv11_input #(
      .DATA_WIDTH (DW),
      .ADDR_WIDTH (AW),
      .FIFO_DEPTH (FD)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .base_addr   (base_addr),
      .length      (length),
      .busy        (busy),
      .done        (done),
      .mem_rd_en   (mem_rd_en),
      .mem_addr    (mem_addr),
      .mem_rd_data (mem_rd_data),
      .valid_out   (valid_out),
      .ready_in    (ready_in),
      .data_out    (data_out)
`ifdef CONV11_INPUT_STALL_CNT_EN
      ,
      .stall_cnt   (stall_cnt)
`endif
   );

   always #5 clk = ~clk;

   // Memory model: random contents, 1-cycle read latency, garbage when idle.
   logic [DW-1:0] memarr [1 << AW];
   always @(posedge clk) begin
      mem_rd_data <= mem_rd_en ? memarr[mem_addr] : DW'($urandom);
   end

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Reference model state (expectations for the current cycle).
   bit            armed = 0;
   bit            rst_prev = 0;
   bit            m_busy = 0;
   bit            m_done = 0;
   int            m_base = 0, m_len = 0, m_issued = 0, m_sent = 0, m_stall = 0;
   int            tot_rd = 0, tot_xf = 0;
   bit            prev_valid = 0, prev_ready = 0;
   logic [DW-1:0] prev_data = '0;

   // Per-transfer log, cycle numbers relative to the start-sampling edge.
   int cyc = 0, start_cyc = 0;
   int first_rd = -1, last_rd = -1, first_valid = -1, done_rel = -1;
   int rd_cnt = 0, xf_cnt = 0, busy_cnt = 0, done_count = 0;
   int addr_log[$];

   always @(negedge clk) begin
      bit nx_done;
      nx_done = 0;
      cyc++;
      if (armed) begin
         if (rst_prev) begin
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
            chk("rst_mem_rd_en", mem_rd_en, 0);
            chk("rst_mem_addr", mem_addr, 0);
            chk("rst_valid_out", valid_out, 0);
            chk("rst_data_out", data_out, 0);
         end
         chk("busy", busy, m_busy);
         chk("done", done, m_done);
`ifdef CONV11_INPUT_STALL_CNT_EN
         chk("stall_cnt", stall_cnt, m_stall);
`endif
         if (!rst_prev && prev_valid && !prev_ready) begin
            chk("hold_valid", valid_out, 1);
            chk("hold_data", data_out, prev_data);
         end
         if (busy) busy_cnt++;
         if (done) begin
            done_count++;
            done_rel = cyc - start_cyc;
         end
         if (mem_rd_en) begin
            chk("rd_in_range", (m_busy && m_issued < m_len), 1);
            chk("rd_addr", mem_addr, (m_base + m_issued) % (1 << AW));
            addr_log.push_back(int'(mem_addr));
            if (first_rd < 0) first_rd = cyc - start_cyc;
            last_rd = cyc - start_cyc;
            rd_cnt++;
            m_issued++;
            tot_rd++;
         end
         chk("occupancy_le_depth", (tot_rd - tot_xf) <= FD, 1);
         if (valid_out && first_valid < 0) first_valid = cyc - start_cyc;
         if (valid_out && ready_in) begin
            chk("data", data_out, memarr[(m_base + m_sent) % (1 << AW)]);
            m_sent++;
            tot_xf++;
            xf_cnt++;
            if (m_sent == m_len) nx_done = 1;
         end
         if (valid_out && !ready_in && m_stall < 65535) m_stall++;
         prev_valid = valid_out;
         prev_ready = ready_in;
         prev_data  = data_out;
      end
      // Advance the model to the next cycle from this cycle's inputs.
      rst_prev = rst;
      if (rst) begin
         armed = 1;
         m_busy = 0; m_done = 0; m_len = 0; m_issued = 0; m_sent = 0; m_stall = 0;
         tot_rd = 0; tot_xf = 0; prev_valid = 0;
      end else if (armed) begin
         if (!m_busy && start) begin
            m_base = int'(base_addr);
            m_len = int'(length);
            m_issued = 0; m_sent = 0; m_stall = 0;
            start_cyc = cyc;
            first_rd = -1; last_rd = -1; first_valid = -1; done_rel = -1;
            rd_cnt = 0; xf_cnt = 0; busy_cnt = 0;
            addr_log.delete();
            m_busy = 1;
            m_done = (length == 0);
         end else begin
            if (m_done) m_busy = 0;
            m_done = nx_done;
         end
      end
   end

   // mode 0: ready high; 1: random ready; 2: low for stall_n valid cycles.
   task automatic drive_ready(input int mode, inout int left);
      if (mode == 0) begin
         ready_in = 1'b1;
      end else if (mode == 1) begin
         ready_in = ($urandom_range(0, 3) != 0);
      end else begin
         if (left > 0) begin
            ready_in = 1'b0;
            if (valid_out) left--;
         end else begin
            ready_in = 1'b1;
         end
      end
   endtask

   task automatic wait_done(input int d0, input int mode, inout int left);
      bit got;
      got = 0;
      for (int i = 0; i < 400; i++) begin
         if (done_count != d0) begin
            got = 1;
            break;
         end
         drive_ready(mode, left);
         @(posedge clk);
         #1;
      end
      chk("done_within_budget", got, 1);
   endtask

   // Called at posedge+1: start is sampled at the next edge (cycle 0).
   task automatic do_xfer(input int b, input int len, input int mode, input int stall_n);
      int d0;
      int left;
      d0 = done_count;
      left = stall_n;
      start = 1'b1;
      base_addr = AW'(b);
      length = (AW + 1)'(len);
      drive_ready(mode, left);
      @(posedge clk);
      #1;
      start = 1'b0;
      wait_done(d0, mode, left);
   endtask

   initial begin
      int d0;
      int left;
      for (int i = 0; i < (1 << AW); i++) memarr[i] = DW'($urandom);
      rst = 1'b1; start = 1'b0; base_addr = '0; length = '0; ready_in = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Basic 8-word transfer with ready held high.
      do_xfer(32'h010, 8, 0, 0);
      chk("t1_first_rd_cycle", first_rd, 1);
      chk("t1_last_rd_cycle", last_rd, 8);
      chk("t1_rd_count", rd_cnt, 8);
      chk("t1_first_valid_cycle", first_valid, 3);
      chk("t1_xfer_count", xf_cnt, 8);
      chk("t1_done_cycle", done_rel, 11);
      chk("t1_busy_cycles", busy_cnt, 11);
      chk("t1_addr0", addr_log[0], 32'h010);
      chk("t1_addr7", addr_log[7], 32'h017);

      // Zero-length transfer, started in the cycle right after done.
      do_xfer(32'h123, 0, 0, 0);
      chk("t2_done_cycle", done_rel, 1);
      chk("t2_rd_count", rd_cnt, 0);
      chk("t2_never_valid", first_valid < 0, 1);
      chk("t2_busy_cycles", busy_cnt, 1);

      // Address wrap-around with random back-pressure.
      do_xfer(32'h3FE, 4, 1, 0);
      chk("t3_addr0", addr_log[0], 32'h3FE);
      chk("t3_addr1", addr_log[1], 32'h3FF);
      chk("t3_addr2", addr_log[2], 32'h000);
      chk("t3_addr3", addr_log[3], 32'h001);
      chk("t3_xfer_count", xf_cnt, 4);

      // 16 words, ready low for 10 cycles after the first valid.
      do_xfer(32'h080, 16, 2, 10);
      chk("t4_xfer_count", xf_cnt, 16);
      chk("t4_rd_count", rd_cnt, 16);
`ifdef CONV11_INPUT_STALL_CNT_EN
      chk("t4_stall_cnt", stall_cnt, 10);
      repeat (3) @(posedge clk);
      #1;
      chk("t4_stall_cnt_hold", stall_cnt, 10);
`endif

      // Reset in the cycle after the third transfer, then a fresh 2-word run.
      d0 = done_count;
      start = 1'b1; base_addr = 10'h100; length = 11'd8; ready_in = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      for (int i = 0; i < 50 && xf_cnt < 3; i++) begin
         @(posedge clk);
         #1;
      end
      chk("t5_three_xfers", xf_cnt, 3);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      chk("t5_no_done_after_rst", done_count, d0);
      do_xfer(32'h200, 2, 0, 0);
      chk("t5_xfer_count", xf_cnt, 2);
      chk("t5_rd_count", rd_cnt, 2);
      chk("t5_addr0", addr_log[0], 32'h200);

      // Start pulsed mid-transfer must be ignored.
      d0 = done_count;
      left = 0;
      start = 1'b1; base_addr = 10'h050; length = 11'd6; ready_in = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      start = 1'b1; base_addr = 10'h300; length = 11'd5;
      @(posedge clk);
      #1;
      start = 1'b0;
      wait_done(d0, 1, left);
      repeat (6) @(posedge clk);
      #1;
      chk("t6_single_done", done_count, d0 + 1);
      chk("t6_rd_count", rd_cnt, 6);
      chk("t6_addr0", addr_log[0], 32'h050);

      // Random transfers with random back-pressure.
      for (int n = 0; n < 15; n++) begin
         int b;
         int len;
         b = int'($urandom_range(0, (1 << AW) - 1));
         len = int'($urandom_range(0, 20));
         do_xfer(b, len, 1, 0);
         chk("rand_xfer_count", xf_cnt, len);
      end

      repeat (3) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
